// File: rtl/crc_pkg.sv
// Shared types and well-known generator polynomials for the CRC stream engine.
package crc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  localparam logic [7:0]  CRC8_POLY        = 8'h07;
  localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
  localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

endpackage

// File: rtl/crc_beat_update.sv
// Combinational CRC advance over one full data beat, one shift-register step per bit.
module crc_beat_update #(
  parameter int unsigned CRC_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          REFLECT_IN = 1'b0
) (
  input  logic [CRC_WIDTH-1:0]  crc_in,
  input  logic [CRC_WIDTH-1:0]  poly,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CRC_WIDTH-1:0]  crc_out
);

  logic fb;

  always_comb begin
    crc_out = crc_in;
    fb      = 1'b0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fb      = crc_out[CRC_WIDTH-1] ^ (REFLECT_IN ? data[i] : data[DATA_WIDTH-1-i]);
      crc_out = {crc_out[CRC_WIDTH-2:0], 1'b0} ^ (fb ? poly : '0);
    end
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: accepts beats of a frame, then presents the final CRC until consumed.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter int unsigned CRC_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  abort,
  input  logic [CRC_WIDTH-1:0]  crc_init,
  input  logic [CRC_WIDTH-1:0]  crc_poly,
  input  logic [CRC_WIDTH-1:0]  crc_xorout,
  input  logic [CRC_WIDTH-1:0]  chk_value,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CRC_WIDTH-1:0]  m_crc,
  output logic                  m_match,
  output logic [15:0]           m_beats
);

  state_e               state_q;
  logic [CRC_WIDTH-1:0] crc_q, poly_q, xorout_q, chk_q;
  logic [CRC_WIDTH-1:0] seed, poly_sel, xorout_sel, chk_sel;
  logic [CRC_WIDTH-1:0] crc_next, crc_ref, crc_final;
  logic [15:0]          beats_q, beats_next;
  logic                 first;

  assign s_ready = (state_q != StDone);
  assign first   = (state_q == StIdle);

  // The first beat of a frame works from the live config; later beats use the latched copy.
  always_comb begin
    seed       = first ? crc_init   : crc_q;
    poly_sel   = first ? crc_poly   : poly_q;
    xorout_sel = first ? crc_xorout : xorout_q;
    chk_sel    = first ? chk_value  : chk_q;
    if (first) begin
      beats_next = 16'd1;
    end else if (beats_q == 16'hFFFF) begin
      beats_next = beats_q;
    end else begin
      beats_next = beats_q + 16'd1;
    end
  end

  crc_beat_update #(
    .CRC_WIDTH  (CRC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .REFLECT_IN (REFLECT_IN)
  ) u_beat_update (
    .crc_in  (seed),
    .poly    (poly_sel),
    .data    (s_data),
    .crc_out (crc_next)
  );

  always_comb begin
    crc_ref = crc_next;
    if (REFLECT_OUT) begin
      for (int unsigned i = 0; i < CRC_WIDTH; i++) begin
        crc_ref[i] = crc_next[CRC_WIDTH-1-i];
      end
    end
    crc_final = crc_ref ^ xorout_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      crc_q    <= '0;
      poly_q   <= '0;
      xorout_q <= '0;
      chk_q    <= '0;
      beats_q  <= '0;
      m_valid  <= 1'b0;
      m_crc    <= '0;
      m_match  <= 1'b0;
      m_beats  <= '0;
    end else begin
      case (state_q)
        StIdle, StBusy: begin
          // abort wins over a beat presented in the same cycle
          if (abort) begin
            state_q <= StIdle;
          end else if (s_valid) begin
            crc_q   <= crc_next;
            beats_q <= beats_next;
            if (first) begin
              poly_q   <= crc_poly;
              xorout_q <= crc_xorout;
              chk_q    <= chk_value;
            end
            if (s_last) begin
              state_q <= StDone;
              m_valid <= 1'b1;
              m_crc   <= crc_final;
              m_match <= (crc_final == chk_sel);
              m_beats <= beats_next;
            end else begin
              state_q <= StBusy;
            end
          end
        end
        StDone: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: directed and random frames against a polynomial-division model.
module tb_crc_stream_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared byte-wide stream driving three configurations in lock-step.
  logic       s_valid, s_last, abort, m_ready;
  logic [7:0] s_data;

  logic [7:0]  init8, poly8, xor8, chk8, m_crc8;
  logic        s_ready8, m_valid8, m_match8;
  logic [15:0] m_beats8;

  logic [15:0] init16, poly16, xor16, chk16, m_crc16;
  logic        s_ready16, m_valid16, m_match16;
  logic [15:0] m_beats16;

  logic [31:0] init32, poly32, xor32, chk32, m_crc32;
  logic        s_ready32, m_valid32, m_match32;
  logic [15:0] m_beats32;

  // Word-wide reflected CRC-32 instance with its own stream.
  logic        w_valid, w_last, w_abort, w_mready, w_sready, w_mvalid, w_match;
  logic [31:0] w_data, w_chk, w_crc;
  logic [15:0] w_beats;

  crc_stream_engine #(.CRC_WIDTH(8), .DATA_WIDTH(8), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)) u8 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready8), .s_data(s_data),
    .s_last(s_last), .abort(abort), .crc_init(init8), .crc_poly(poly8), .crc_xorout(xor8),
    .chk_value(chk8), .m_valid(m_valid8), .m_ready(m_ready), .m_crc(m_crc8),
    .m_match(m_match8), .m_beats(m_beats8)
  );

  crc_stream_engine #(.CRC_WIDTH(16), .DATA_WIDTH(8), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)) u16 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready16), .s_data(s_data),
    .s_last(s_last), .abort(abort), .crc_init(init16), .crc_poly(poly16), .crc_xorout(xor16),
    .chk_value(chk16), .m_valid(m_valid16), .m_ready(m_ready), .m_crc(m_crc16),
    .m_match(m_match16), .m_beats(m_beats16)
  );

  crc_stream_engine #(.CRC_WIDTH(32), .DATA_WIDTH(8), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready32), .s_data(s_data),
    .s_last(s_last), .abort(abort), .crc_init(init32), .crc_poly(poly32), .crc_xorout(xor32),
    .chk_value(chk32), .m_valid(m_valid32), .m_ready(m_ready), .m_crc(m_crc32),
    .m_match(m_match32), .m_beats(m_beats32)
  );

  crc_stream_engine #(.CRC_WIDTH(32), .DATA_WIDTH(32), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)) uw (
    .clk(clk), .rst_n(rst_n), .s_valid(w_valid), .s_ready(w_sready), .s_data(w_data),
    .s_last(w_last), .abort(w_abort), .crc_init(32'hFFFF_FFFF), .crc_poly(32'h04C1_1DB7),
    .crc_xorout(32'hFFFF_FFFF), .chk_value(w_chk), .m_valid(w_mvalid), .m_ready(w_mready),
    .m_crc(w_crc), .m_match(w_match), .m_beats(w_beats)
  );

  int errors = 0;
  int checks = 0;
  logic [63:0] msg[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Remainder of (init * x^n + M(x) * x^w) modulo (x^w + poly) by long division.
  function automatic logic [31:0] ref_crc(input int w, input int dw, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xorout,
                                          input bit refin, input bit refout);
    bit a[$];
    int n;
    logic [31:0] rem;
    foreach (msg[m]) begin
      for (int i = 0; i < dw; i++) a.push_back(refin ? msg[m][i] : msg[m][dw-1-i]);
    end
    n = a.size();
    for (int i = 0; i < w; i++) a.push_back(1'b0);
    for (int i = 0; i < w; i++) a[i] = a[i] ^ init[w-1-i];
    for (int k = 0; k < n; k++) begin
      if (a[k]) begin
        a[k] = 1'b0;
        for (int j = 0; j < w; j++) a[k+1+j] = a[k+1+j] ^ poly[w-1-j];
      end
    end
    rem = '0;
    for (int j = 0; j < w; j++) begin
      if (refout) rem[j] = a[n+j];
      else        rem[w-1-j] = a[n+j];
    end
    return rem ^ xorout;
  endfunction

  // Drives msg onto the byte stream; scramble=1 alters the live config after the first beat.
  task automatic send_narrow(input bit scramble);
    for (int k = 0; k < msg.size(); k++) begin
      s_valid = 1'b1;
      s_data  = msg[k][7:0];
      s_last  = (k == msg.size() - 1);
      step();
      if (scramble && k == 0) begin
        init8 = 8'hAA; poly8 = 8'hFF; xor8 = 8'h55; chk8 = 8'h00;
        init16 = 16'h1234; poly16 = 16'h8005; xor16 = 16'hFFFF; chk16 = 16'h0000;
        poly32 = 32'h1EDC_6F41; chk32 = 32'h0;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("m_valid_latency", {63'b0, m_valid8}, 64'd1);
  endtask

  task automatic load_msg(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back({56'b0, s[i]});
  endtask

  task automatic std_cfg();
    init8 = 8'h00; poly8 = 8'h07; xor8 = 8'h00; chk8 = 8'hF4;
    init16 = 16'hFFFF; poly16 = 16'h1021; xor16 = 16'h0000; chk16 = 16'h29B1;
    init32 = 32'hFFFF_FFFF; poly32 = 32'h04C1_1DB7; xor32 = 32'hFFFF_FFFF; chk32 = 32'hCBF4_3926;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp8, exp16, exp32;
    int len, stall;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; abort = 1'b0; m_ready = 1'b1;
    w_valid = 1'b0; w_last = 1'b0; w_data = '0; w_abort = 1'b0; w_mready = 1'b1; w_chk = '0;
    std_cfg();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {63'b0, m_valid8}, 64'd0);
    check("rst_m_crc", {56'b0, m_crc8}, 64'd0);
    check("rst_m_match", {63'b0, m_match8}, 64'd0);
    check("rst_m_beats", {48'b0, m_beats8}, 64'd0);
    rst_n = 1'b1;
    step();
    check("rst_s_ready", {63'b0, s_ready8}, 64'd1);

    // Check string on all three byte-wide configs, config changed mid-frame, result stalled.
    load_msg("123456789");
    m_ready = 1'b0;
    send_narrow(1'b1);
    check("crc8_check", {56'b0, m_crc8}, 64'hF4);
    check("crc8_beats", {48'b0, m_beats8}, 64'd9);
    check("crc8_match", {63'b0, m_match8}, 64'd1);
    check("crc8_model", {56'b0, m_crc8}, {32'b0, ref_crc(8, 8, 32'h07, 32'h0, 32'h0, 0, 0)});
    check("crc16_check", {48'b0, m_crc16}, 64'h29B1);
    check("crc16_match", {63'b0, m_match16}, 64'd1);
    check("crc32_check", {32'b0, m_crc32}, 64'hCBF4_3926);
    check("crc32_match", {63'b0, m_match32}, 64'd1);
    std_cfg();
    for (int c = 0; c < 5; c++) begin
      abort   = (c == 1);
      s_valid = (c >= 2);
      s_data  = 8'h55;
      s_last  = (c == 3);
      check("stall_s_ready", {63'b0, s_ready8}, 64'd0);
      check("stall_m_valid", {63'b0, m_valid8}, 64'd1);
      check("stall_m_crc", {56'b0, m_crc8}, 64'hF4);
      check("stall_m_beats", {48'b0, m_beats8}, 64'd9);
      step();
    end
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check("stall_end_crc", {56'b0, m_crc8}, 64'hF4);
    m_ready = 1'b1;
    step();
    check("handshake_m_valid", {63'b0, m_valid8}, 64'd0);
    check("handshake_s_ready", {63'b0, s_ready8}, 64'd1);
    load_msg("1");
    send_narrow(1'b0);
    check("after_stall_crc", {56'b0, m_crc8}, 64'h97);
    check("after_stall_beats", {48'b0, m_beats8}, 64'd1);
    step();
    check("after_stall_done", {63'b0, m_valid8}, 64'd0);

    // Abort together with a beat mid-frame, then a clean frame.
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
      step();
    end
    abort = 1'b1; s_data = 8'hEE; s_last = 1'b1;
    step();
    abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    check("abort_no_valid", {63'b0, m_valid8}, 64'd0);
    check("abort_s_ready", {63'b0, s_ready8}, 64'd1);
    step();
    check("abort_still_idle", {63'b0, m_valid8}, 64'd0);
    msg.delete();
    for (int k = 0; k < 3; k++) msg.push_back({56'b0, 8'($urandom)});
    send_narrow(1'b0);
    check("abort_clean_crc", {56'b0, m_crc8},
          {32'b0, ref_crc(8, 8, 32'h07, 32'h0, 32'h0, 0, 0)});
    check("abort_clean_beats", {48'b0, m_beats8}, 64'd3);
    step();

    // Word-wide reflected CRC-32: "12345678" then a random three-word frame.
    for (int f = 0; f < 2; f++) begin
      msg.delete();
      if (f == 0) begin
        msg.push_back(64'h3433_3231);
        msg.push_back(64'h3837_3635);
      end else begin
        for (int k = 0; k < 3; k++) msg.push_back({32'b0, $urandom});
      end
      for (int k = 0; k < msg.size(); k++) begin
        w_valid = 1'b1; w_data = msg[k][31:0]; w_last = (k == msg.size() - 1);
        step();
      end
      w_valid = 1'b0; w_last = 1'b0;
      check("wide_m_valid", {63'b0, w_mvalid}, 64'd1);
      check("wide_crc", {32'b0, w_crc},
            {32'b0, ref_crc(32, 32, 32'h04C1_1DB7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1)});
      check("wide_beats", {48'b0, w_beats}, {32'b0, 32'(msg.size())});
      step();
    end

    // Random frames with random configs and result back-pressure.
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 6);
      stall = $urandom_range(0, 2);
      msg.delete();
      for (int k = 0; k < len; k++) msg.push_back({56'b0, 8'($urandom)});
      init8 = 8'($urandom); poly8 = 8'($urandom); xor8 = 8'($urandom);
      exp8  = ref_crc(8, 8, {24'b0, poly8}, {24'b0, init8}, {24'b0, xor8}, 0, 0);
      chk8  = ($urandom_range(0, 1) == 1) ? exp8[7:0] : 8'($urandom);
      exp16 = ref_crc(16, 8, {16'b0, poly16}, {16'b0, init16}, {16'b0, xor16}, 0, 0);
      exp32 = ref_crc(32, 8, poly32, init32, xor32, 1, 1);
      m_ready = (stall == 0);
      send_narrow(1'b0);
      check("rand_crc8", {56'b0, m_crc8}, {32'b0, exp8});
      check("rand_match8", {63'b0, m_match8}, {63'b0, (exp8[7:0] == chk8)});
      check("rand_beats8", {48'b0, m_beats8}, {32'b0, 32'(len)});
      check("rand_crc16", {48'b0, m_crc16}, {32'b0, exp16});
      check("rand_crc32", {32'b0, m_crc32}, {32'b0, exp32});
      for (int c = 0; c < stall; c++) step();
      m_ready = 1'b1;
      step();
      check("rand_released", {63'b0, m_valid8}, 64'd0);
    end

    // Beat counter saturation.
    std_cfg();
    for (int i = 0; i < 65537; i++) begin
      s_valid = 1'b1; s_data = 8'(i); s_last = (i == 65536);
      step();
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("sat_m_valid", {63'b0, m_valid8}, 64'd1);
    check("sat_beats", {48'b0, m_beats8}, 64'hFFFF);
    step();

    // Asynchronous reset mid-frame, then a single-beat frame.
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b0;
      step();
    end
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_m_crc", {56'b0, m_crc8}, 64'd0);
    check("arst_m_beats", {48'b0, m_beats8}, 64'd0);
    check("arst_m_valid", {63'b0, m_valid8}, 64'd0);
    check("arst_m_crc16", {48'b0, m_crc16}, 64'd0);
    #3 rst_n = 1'b1;
    step();
    check("arst_s_ready", {63'b0, s_ready8}, 64'd1);
    chk8 = 8'h97;
    load_msg("1");
    send_narrow(1'b0);
    check("arst_crc", {56'b0, m_crc8}, 64'h97);
    check("arst_match", {63'b0, m_match8}, 64'd1);
    check("arst_beats", {48'b0, m_beats8}, 64'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
